// File: rtl/sqrt_generic_pipe.sv
// Fully pipelined restoring integer square root: one root bit per stage, MSB first,
// plus the generic delay line used for the valid flag.

module sqrt_generic_pipe #(
    parameter int WIDTH_INPUT  = 16,
    parameter int WIDTH_OUTPUT = WIDTH_INPUT / 2 + WIDTH_INPUT % 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [WIDTH_INPUT-1:0]  radicand,
    output logic                    valid_out,
    output logic [WIDTH_OUTPUT-1:0] root
);

    localparam int W_EXT = 2 * WIDTH_OUTPUT;
    localparam int W_REM = WIDTH_OUTPUT + 2;

    logic [W_EXT-1:0] radicand_ext_s;

    // Odd widths gain one zero MSB so every stage consumes exactly two bits.
    assign radicand_ext_s = W_EXT'(radicand);

    genvar i;
    for (i = 0; i < WIDTH_OUTPUT; i++) begin : g_stage
        // Only the not-yet-consumed radicand bits travel down the pipe.
        localparam int RAD_IN = W_EXT - 2 * i;

        logic [W_REM-1:0]        rem_prev_s;
        logic [WIDTH_OUTPUT-1:0] root_prev_s;
        logic [RAD_IN-1:0]       rad_prev_s;
        logic [W_REM-1:0]        shifted_s;
        logic [W_REM-1:0]        trial_s;
        logic                    take_s;
        logic [WIDTH_OUTPUT-1:0] root_r;

        if (i == 0) begin : g_first
            assign rem_prev_s  = '0;
            assign root_prev_s = '0;
            assign rad_prev_s  = radicand_ext_s;
        end else begin : g_next
            assign rem_prev_s  = g_stage[i-1].g_carry.rem_r;
            assign root_prev_s = g_stage[i-1].root_r;
            assign rad_prev_s  = g_stage[i-1].g_carry.rad_r;
        end

        assign shifted_s = W_REM'({rem_prev_s, rad_prev_s[RAD_IN-1 -: 2]});
        assign trial_s   = {root_prev_s, 2'b01};
        assign take_s    = (shifted_s >= trial_s);

        // Partial root register: append the resolved bit.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                root_r <= '0;
            end else if (take_s) begin
                root_r <= WIDTH_OUTPUT'({root_prev_s, 1'b1});
            end else begin
                root_r <= WIDTH_OUTPUT'({root_prev_s, 1'b0});
            end
        end

        if (i < WIDTH_OUTPUT - 1) begin : g_carry
            localparam int RAD_OUT = RAD_IN - 2;

            logic [W_REM-1:0]   rem_r;
            logic [RAD_OUT-1:0] rad_r;

            // Remainder and remaining radicand bits for the next stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rem_r <= '0;
                    rad_r <= '0;
                end else begin
                    rem_r <= take_s ? (shifted_s - trial_s) : shifted_s;
                    rad_r <= rad_prev_s[RAD_OUT-1:0];
                end
            end
        end
    end

    assign root = g_stage[WIDTH_OUTPUT-1].root_r;

    pipeline_registers #(
        .BIT_WIDTH        (1),
        .NUMBER_OF_STAGES (WIDTH_OUTPUT)
    ) u_valid_pipe (
        .clk      (clk),
        .reset_n  (rst_n),
        .pipe_in  (valid_in),
        .pipe_out (valid_out)
    );

endmodule

module pipeline_registers #(
    parameter int BIT_WIDTH        = 1,
    parameter int NUMBER_OF_STAGES = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [BIT_WIDTH-1:0] pipe_in,
    output logic [BIT_WIDTH-1:0] pipe_out
);

    if (NUMBER_OF_STAGES == 0) begin : g_bypass
        assign pipe_out = pipe_in;
    end else begin : g_chain
        logic [BIT_WIDTH-1:0] stage_r [NUMBER_OF_STAGES];

        // Shift chain, cleared as a whole on reset.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int k = 0; k < NUMBER_OF_STAGES; k++) begin
                    stage_r[k] <= '0;
                end
            end else begin
                stage_r[0] <= pipe_in;
                for (int k = 1; k < NUMBER_OF_STAGES; k++) begin
                    stage_r[k] <= stage_r[k-1];
                end
            end
        end

        assign pipe_out = stage_r[NUMBER_OF_STAGES-1];
    end

endmodule

// File: tb/tb_sqrt_generic_pipe.sv
// Self-checking bench for sqrt_generic_pipe: corner table, valid gating, resets,
// exhaustive stream and an odd-width instance, all through timed scoreboards.

module tb_sqrt_generic_pipe;

    localparam int LAT16 = 8;
    localparam int LAT7  = 4;

    typedef struct {
        logic [15:0] rad;
        logic [7:0]  exp;
    } vec_t;

    typedef struct {
        int          due;
        logic [7:0]  root;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [15:0] radicand;
    logic        valid_out;
    logic [7:0]  root;
    logic [15:0] dly_rad;

    logic        valid_in7;
    logic [6:0]  radicand7;
    logic        valid_out7;
    logic [3:0]  root7;

    int  cyc;
    int  checks;
    int  errors;
    bit  mon_en;
    sb_t q16[$];
    sb_t q7[$];

    sqrt_generic_pipe #(.WIDTH_INPUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .radicand  (radicand),
        .valid_out (valid_out),
        .root      (root)
    );

    sqrt_generic_pipe #(.WIDTH_INPUT(7)) dut7 (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in7),
        .radicand  (radicand7),
        .valid_out (valid_out7),
        .root      (root7)
    );

    pipeline_registers #(.BIT_WIDTH(16), .NUMBER_OF_STAGES(LAT16)) u_align (
        .clk      (clk),
        .reset_n  (rst_n),
        .pipe_in  (radicand),
        .pipe_out (dly_rad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] isqrt16(input logic [15:0] x);
        int r;
        r = 0;
        for (int b = 7; b >= 0; b--) begin
            int t;
            t = r | (1 << b);
            if (t * t <= int'(x)) r = t;
        end
        return r[7:0];
    endfunction

    task automatic drive(input logic v, input logic [15:0] r, input logic [7:0] e);
        sb_t s;
        @(negedge clk);
        valid_in = v;
        radicand = r;
        if (v) begin
            s.due  = cyc + LAT16;
            s.root = e;
            q16.push_back(s);
        end
    endtask

    task automatic drive7(input logic v, input logic [6:0] r, input logic [3:0] e);
        sb_t s;
        @(negedge clk);
        valid_in7 = v;
        radicand7 = r;
        if (v) begin
            s.due  = cyc + LAT7;
            s.root = {4'd0, e};
            q7.push_back(s);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q16.size() > 0 || q7.size() > 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q16.size() > 0 || q7.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: pending16=%0d pending7=%0d required 0", q16.size(), q7.size());
            q16.delete();
            q7.delete();
        end
    endtask

    // Timed scoreboard for the 16-bit unit, including the root-property check on the aligned radicand.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            while (q16.size() > 0 && q16[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_valid16: due cycle %0d got no valid_out, required valid_out=1", q16[0].due);
                void'(q16.pop_front());
            end
            if (valid_out !== 1'b0) begin
                checks++;
                if (q16.size() == 0 || q16[0].due != cyc) begin
                    errors++;
                    $display("FAIL unexpected_valid16: cycle %0d valid_out=%b required 0", cyc, valid_out);
                end else begin
                    int rt;
                    if (root !== q16[0].root) begin
                        errors++;
                        $display("FAIL root16: cycle %0d root=%0d required %0d", cyc, root, q16[0].root);
                    end
                    void'(q16.pop_front());
                    rt = int'(root);
                    checks++;
                    if (!(rt * rt <= int'(dly_rad) && int'(dly_rad) < (rt + 1) * (rt + 1))) begin
                        errors++;
                        $display("FAIL root_bound16: radicand=%0d root=%0d required root^2<=r<(root+1)^2", dly_rad, root);
                    end
                end
            end
        end
    end

    // Timed scoreboard for the odd-width unit.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            while (q7.size() > 0 && q7[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_valid7: due cycle %0d got no valid_out, required valid_out=1", q7[0].due);
                void'(q7.pop_front());
            end
            if (valid_out7 !== 1'b0) begin
                checks++;
                if (q7.size() == 0 || q7[0].due != cyc) begin
                    errors++;
                    $display("FAIL unexpected_valid7: cycle %0d valid_out=%b required 0", cyc, valid_out7);
                end else begin
                    if ({4'd0, root7} !== q7[0].root) begin
                        errors++;
                        $display("FAIL root7: cycle %0d root=%0d required %0d", cyc, root7, q7[0].root);
                    end
                    void'(q7.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        logic gate_pat[5];

        tbl[0] = '{16'd0,     8'd0};
        tbl[1] = '{16'd1,     8'd1};
        tbl[2] = '{16'd2,     8'd1};
        tbl[3] = '{16'd3,     8'd1};
        tbl[4] = '{16'd4,     8'd2};
        tbl[5] = '{16'd255,   8'd15};
        tbl[6] = '{16'd256,   8'd16};
        tbl[7] = '{16'd65024, 8'd254};
        tbl[8] = '{16'd65025, 8'd255};
        tbl[9] = '{16'd65535, 8'd255};
        gate_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        cyc       = 0;
        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        rst_n     = 1'b0;
        valid_in  = 1'b1;
        radicand  = 16'hFFFF;
        valid_in7 = 1'b1;
        radicand7 = 7'h7F;

        // Reset held with valid asserted: outputs must stay cleared.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (valid_out !== 1'b0 || root !== 8'd0 || valid_out7 !== 1'b0 || root7 !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold: valid_out=%b root=%0d valid_out7=%b root7=%0d required 0 0 0 0",
                         valid_out, root, valid_out7, root7);
            end
        end
        valid_in  = 1'b0;
        valid_in7 = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 10; k++) drive(1'b1, tbl[k].rad, tbl[k].exp);
        drive(1'b0, 16'd0, 8'd0);
        drain();

        for (int k = 0; k < 5; k++) begin
            logic [15:0] r;
            r = 16'((k + 1) * 1000);
            drive(gate_pat[k], r, isqrt16(r));
        end
        drive(1'b0, 16'd0, 8'd0);
        drain();

        drive7(1'b1, 7'd127, 4'd11);
        drive7(1'b1, 7'd100, 4'd10);
        drive7(1'b0, 7'd50,  4'd7);
        drive7(1'b1, 7'd99,  4'd9);
        drive7(1'b1, 7'd0,   4'd0);
        drive7(1'b0, 7'd0,   4'd0);
        drain();

        // Mid-stream reset with a full pipe: everything in flight is discarded.
        for (int k = 0; k < 8; k++) begin
            logic [15:0] r;
            r = 16'(40000 + k * 3001);
            drive(1'b1, r, isqrt16(r));
        end
        drive(1'b0, 16'd0, 8'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q16.delete();
        #1;
        checks++;
        if (valid_out !== 1'b0 || root !== 8'd0) begin
            errors++;
            $display("FAIL midreset_async: valid_out=%b root=%0d required 0 0", valid_out, root);
        end
        #1;
        rst_n = 1'b1;
        repeat (10) drive(1'b0, 16'd0, 8'd0);
        drive(1'b1, 16'd12345, isqrt16(16'd12345));
        drive(1'b0, 16'd0, 8'd0);
        drain();

        for (int r = 0; r < 65536; r++) drive(1'b1, 16'(r), isqrt16(16'(r)));
        drive(1'b0, 16'd0, 8'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
